// File: rtl/mult_div_unit_if.sv
// Handshake and result bus of the iterative multiply/divide unit.
// Command, direct-write and status/result signals are bundled together.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, with sign fix-up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               dz_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               done;
  logic               div_zero;

  logic               is_div;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               b_zero;

  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH:0]   mul_wide;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  // Magnitudes of the incoming operands; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    is_div    = bus.op[1];
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.a[WIDTH-1];
    b_neg     = is_signed & bus.b[WIDTH-1];
    mag_a     = a_neg ? -bus.a : bus.a;
    mag_b     = b_neg ? -bus.b : bus.b;
    b_zero    = (bus.b == '0);
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    add_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_wide = {add_hi, acc[WIDTH-1:0]};
    mul_next = mul_wide[2*WIDTH:1];
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    mul_res  = neg_q ? -acc : acc;
    quo_res  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_res  = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_hi) hi <= bus.wr_data;
          if (bus.wr_lo) lo <= bus.wr_data;
          if (bus.start) begin
            is_div_q  <= is_div;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= is_div & b_zero;
            cnt       <= '0;
            opnd      <= is_div ? mag_b : mag_a;
            acc       <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            state     <= (is_div && b_zero) ? FIX : CALC;
          end
        end
        CALC: begin
          acc <= is_div_q ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          done     <= 1'b1;
          div_zero <= dz_q;
          // A zero divisor leaves HI/LO exactly as they were.
          if (!dz_q) begin
            if (is_div_q) begin
              hi <= rem_res;
              lo <= quo_res;
            end else begin
              hi <= mul_res[2*WIDTH-1:WIDTH];
              lo <= mul_res[WIDTH-1:0];
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.div_zero = div_zero;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences, and random operations against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;
  localparam int LAT_RUN = W + 2;
  localparam int LAT_DZ = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Result of one operation computed directly from the arithmetic definition.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                   output logic [31:0] e_hi, output logic [31:0] e_lo,
                                   output logic e_dz);
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e_dz = 1'b0;
    e_hi = cur_hi;
    e_lo = cur_lo;
    case (op)
      2'b00: begin
        sp = sa * sb;
        e_hi = 32'(sp >>> 32);
        e_lo = 32'(sp);
      end
      2'b01: begin
        up = 64'(a) * 64'(b);
        e_hi = 32'(up >> 32);
        e_lo = 32'(up);
      end
      default: begin
        if (b == 32'd0) begin
          e_dz = 1'b1;
        end else if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          e_lo = 32'(sq);
          e_hi = 32'(sr);
        end else begin
          e_lo = a / b;
          e_hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    bus.wr_hi = 1'b1;
    bus.wr_data = h;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b1;
    bus.wr_data = l;
    @(negedge clk);
    bus.wr_lo = 1'b0;
  endtask

  // Launch one operation and wait (bounded) for done; cycle 1 is the cycle after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r_hi, output logic [31:0] r_lo,
                               output logic r_dz, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
    checkOutput("done_dz_low_cycle1", 32'({bus.done, bus.div_zero}), 32'd0);
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r_hi = bus.hi;
    r_lo = bus.lo;
    r_dz = bus.div_zero;
    checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("done_single_pulse", 32'({bus.done, bus.div_zero}), 32'd0);
  endtask

  initial begin
    logic [31:0] r_hi, r_lo, e_hi, e_lo, m_hi, m_lo;
    logic        r_dz, e_dz;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    int          lat;

    total = 0;
    bad = 0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wr_data = '0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, LAT_RUN};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT_RUN};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_RUN};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000, 1'b0, LAT_RUN};
    vecs[4]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 1'b1, LAT_DZ};
    vecs[5]  = '{2'b11, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 1'b0, LAT_RUN};
    vecs[6]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'd1, 32'hFFFFFFFD, 1'b0, LAT_RUN};
    vecs[7]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9, 32'h9, 32'h0, 32'h1, 1'b0, LAT_RUN};
    vecs[8]  = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB, 1'b1, LAT_DZ};
    vecs[9]  = '{2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h3, 32'h4, 32'h0, 32'h0, 1'b0, LAT_RUN};
    vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h0, 1'b0, LAT_RUN};

    // Reset state.
    rst = 1'b0;
    #12;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'({bus.done, bus.div_zero}), 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 11; i++) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_dz, lat);
      checkOutput($sformatf("vec%0d_hi", i), r_hi, vecs[i].exp_hi);
      checkOutput($sformatf("vec%0d_lo", i), r_lo, vecs[i].exp_lo);
      checkOutput($sformatf("vec%0d_dz", i), 32'(r_dz), 32'(vecs[i].exp_dz));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    $display("[TB] direct write together with accepted start");
    preload(32'h0, 32'h0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd2;
    bus.b = 32'd3;
    bus.wr_hi = 1'b1;
    bus.wr_data = 32'h0000ABCD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    checkOutput("same_cycle_wr_hi", bus.hi, 32'h0000ABCD);
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("same_cycle_result_hi", bus.hi, 32'd0);
    checkOutput("same_cycle_result_lo", bus.lo, 32'd6);
    @(negedge clk);

    $display("[TB] start and wr_hi while busy are ignored");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd1000;
    bus.b = 32'd1000;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 5) begin
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd7;
        bus.b = 32'd9;
        bus.wr_hi = 1'b1;
        bus.wr_data = 32'hDEADBEEF;
      end else begin
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    checkOutput("busy_ignore_latency", 32'(lat), 32'(LAT_RUN));
    checkOutput("busy_ignore_hi", bus.hi, 32'd0);
    checkOutput("busy_ignore_lo", bus.lo, 32'd1000000);
    @(negedge clk);
    checkOutput("busy_ignore_no_second_op", 32'(bus.busy), 32'd0);

    $display("[TB] reset in the middle of CALC");
    preload(32'h5555, 32'hAAAA);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.a = 32'd7;
    bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    checkOutput("midop_busy_before_reset", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midop_reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midop_reset_hi", bus.hi, 32'd0);
    checkOutput("midop_reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b01, 32'd3, 32'd4, r_hi, r_lo, r_dz, lat);
    checkOutput("post_reset_hi", r_hi, 32'd0);
    checkOutput("post_reset_lo", r_lo, 32'd12);
    checkOutput("post_reset_latency", 32'(lat), 32'(LAT_RUN));

    $display("[TB] random operations against reference model");
    m_hi = 32'h01234567;
    m_lo = 32'h89ABCDEF;
    preload(m_hi, m_lo);
    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: r_b = 32'($urandom_range(0, 3));
        1: r_b = 32'hFFFFFFFF;
        default: r_b = $urandom;
      endcase
      refModel(r_op, r_a, r_b, m_hi, m_lo, e_hi, e_lo, e_dz);
      applyStimulus(r_op, r_a, r_b, r_hi, r_lo, r_dz, lat);
      checkOutput($sformatf("rand%0d_hi op=%0d a=%h b=%h", n, r_op, r_a, r_b), r_hi, e_hi);
      checkOutput($sformatf("rand%0d_lo op=%0d a=%h b=%h", n, r_op, r_a, r_b), r_lo, e_lo);
      checkOutput($sformatf("rand%0d_dz", n), 32'(r_dz), 32'(e_dz));
      checkOutput($sformatf("rand%0d_latency", n), 32'(lat), e_dz ? 32'(LAT_DZ) : 32'(LAT_RUN));
      m_hi = e_hi;
      m_lo = e_lo;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
